// File: rtl/spdif_frame_assembler_if.sv
// Bus between the S/PDIF decoder and the frame assembler.
// Decoder side drives enable/flag/bfr; assembler drives the frame results.
interface spdif_frame_assembler_if #(
    parameter int CS_BITS = 24
);
    logic               enable;
    logic [2:0]         flag;
    logic [24:0]        bfr;
    logic [23:0]        left;
    logic [23:0]        right;
    logic               sample_valid;
    logic [7:0]         frame_idx;
    logic               block_start;
    logic [CS_BITS-1:0] cs_word;
    logic               cs_valid;
    logic               seq_err;
    logic               locked;

    modport master (
        output enable, flag, bfr,
        input  left, right, sample_valid, frame_idx, block_start,
        input  cs_word, cs_valid, seq_err, locked
    );

    modport slave (
        input  enable, flag, bfr,
        output left, right, sample_valid, frame_idx, block_start,
        output cs_word, cs_valid, seq_err, locked
    );
endinterface

// File: rtl/spdif_frame_assembler.sv
// Pairs S/PDIF left/right subframes into frames, tracks block position,
// gathers channel-status bits and flags preamble sequencing errors.
// Ports: clk, rst (async, active high), bus (slave: enable/flag/bfr in,
// left/right/sample_valid/frame_idx/block_start/cs_*/seq_err/locked out).
module spdif_frame_assembler #(
    parameter int FRAMES_PER_BLOCK = 192,
    parameter int CS_BITS          = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    spdif_frame_assembler_if.slave     bus
);

    localparam logic [7:0] LAST_IDX = 8'(FRAMES_PER_BLOCK - 1);
    localparam logic [7:0] BLK_LEN  = 8'(FRAMES_PER_BLOCK);
    localparam logic [7:0] CS_LAST  = 8'(CS_BITS - 1);

    typedef enum logic {
        IDLE,
        HAVE_L
    } state_t;

    state_t               state_q, state_d;
    logic [23:0]          pend_l_q, pend_l_d;
    logic                 pend_c_q, pend_c_d;
    logic                 pend_b_q, pend_b_d;
    logic [23:0]          left_q, left_d;
    logic [23:0]          right_q, right_d;
    // frame_idx doubles as the block position counter
    logic [7:0]           idx_q, idx_d;
    logic [CS_BITS-1:0]   sr_q, sr_d;
    logic [CS_BITS-1:0]   cs_word_q, cs_word_d;
    logic                 sv_q, sv_d;
    logic                 bs_q, bs_d;
    logic                 csv_q, csv_d;
    logic                 err_q, err_d;
    logic                 locked_q, locked_d;

    logic                 flag_b, flag_m, flag_w, one_hot;
    logic                 load, complete;
    logic [7:0]           inc;

    assign flag_b  = (bus.flag == 3'b001);
    assign flag_m  = (bus.flag == 3'b010);
    assign flag_w  = (bus.flag == 3'b100);
    assign one_hot = flag_b | flag_m | flag_w;
    assign inc     = idx_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        pend_l_d  = pend_l_q;
        pend_c_d  = pend_c_q;
        pend_b_d  = pend_b_q;
        left_d    = left_q;
        right_d   = right_q;
        idx_d     = idx_q;
        sr_d      = sr_q;
        cs_word_d = cs_word_q;
        sv_d      = 1'b0;
        bs_d      = 1'b0;
        csv_d     = 1'b0;
        err_d     = 1'b0;
        locked_d  = locked_q;
        load      = 1'b0;
        complete  = 1'b0;

        if (bus.enable) begin
            if (!one_hot) begin
                err_d    = 1'b1;
                state_d  = IDLE;
                pend_l_d = '0;
                pend_c_d = 1'b0;
                pend_b_d = 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (flag_w) err_d = 1'b1;
                        else        load  = 1'b1;
                    end
                    HAVE_L: begin
                        if (flag_w) begin
                            complete = 1'b1;
                        end else begin
                            // a second left restarts the frame
                            err_d = 1'b1;
                            load  = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        if (load) begin
            state_d  = HAVE_L;
            pend_l_d = bus.bfr[23:0];
            pend_c_d = bus.bfr[24];
            pend_b_d = flag_b;
        end

        if (complete) begin
            state_d = IDLE;
            left_d  = pend_l_q;
            right_d = bus.bfr[23:0];
            sv_d    = 1'b1;
            bs_d    = pend_b_q;
            if (pend_b_q) begin
                idx_d = 8'd0;
                // an early B only counts as an error once locked
                if (locked_q && idx_q != LAST_IDX) err_d = 1'b1;
            end else if (inc == BLK_LEN) begin
                // B preamble missing at the block boundary
                idx_d = 8'd0;
                err_d = 1'b1;
            end else begin
                idx_d = inc;
            end
            for (int i = 0; i < CS_BITS; i++) begin
                if (idx_d == 8'(i)) sr_d[i] = pend_c_q;
            end
            if (idx_d == CS_LAST) begin
                cs_word_d = sr_d;
                csv_d     = 1'b1;
            end
            if (pend_b_q) locked_d = 1'b1;
        end

        if (err_d) locked_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pend_l_q  <= '0;
            pend_c_q  <= 1'b0;
            pend_b_q  <= 1'b0;
            left_q    <= '0;
            right_q   <= '0;
            idx_q     <= '0;
            sr_q      <= '0;
            cs_word_q <= '0;
            sv_q      <= 1'b0;
            bs_q      <= 1'b0;
            csv_q     <= 1'b0;
            err_q     <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_l_q  <= pend_l_d;
            pend_c_q  <= pend_c_d;
            pend_b_q  <= pend_b_d;
            left_q    <= left_d;
            right_q   <= right_d;
            idx_q     <= idx_d;
            sr_q      <= sr_d;
            cs_word_q <= cs_word_d;
            sv_q      <= sv_d;
            bs_q      <= bs_d;
            csv_q     <= csv_d;
            err_q     <= err_d;
            locked_q  <= locked_d;
        end
    end

    assign bus.left         = left_q;
    assign bus.right        = right_q;
    assign bus.sample_valid = sv_q;
    assign bus.frame_idx    = idx_q;
    assign bus.block_start  = bs_q;
    assign bus.cs_word      = cs_word_q;
    assign bus.cs_valid     = csv_q;
    assign bus.seq_err      = err_q;
    assign bus.locked       = locked_q;

endmodule
